spindash_mixer: RTL and testbench
=================================

# spindash_mixer

Parametrised, time-multiplexed stereo mixer that replaces the flat combinational adder tree between the `jt12_top` instances and the `delta_sigma_adc` pair. On each new-sample strobe it snapshots every chip's left/right output. It then accumulates them one chip per clock with per-chip, per-side gain. Finally it applies a master attenuation shift and saturates the result to the PDM input width. It adds runtime level control, clip and overrun reporting, and a configuration write port.

## Interface
- `CHIP_COUNT`, default 9: number of chip inputs, range 1..31.
- `IN_W`, default 16: signed sample width per chip.
- `GAIN_W`, default 8: unsigned gain width, Q1.7 format; 0x80 = unity, 0x00 = mute.
- `OUT_W`, default 16: signed mixed-output width.
- `clk`, input, 1: mixer clock (the `clk_jt` domain).
- `rst_n`, input, 1: asynchronous active-low reset.
- `sample_stb`, input, 1: new-sample indication; only its rising edge is used.
- `snd_left_in`, input, CHIP_COUNT*IN_W: packed signed samples, chip i at `[i*IN_W +: IN_W]`.
- `snd_right_in`, input, CHIP_COUNT*IN_W: as `snd_left_in`, right side.
- `cfg_wr`, input, 1: configuration write strobe, one cycle per write.
- `cfg_addr`, input, 6: bit 5 selects side (0 = left, 1 = right); bits 4:0 select the chip index, where 31 is the control register.
- `cfg_data`, input, 8: write data.
- `mix_left`, output, OUT_W: signed mixed left sample.
- `mix_right`, output, OUT_W: signed mixed right sample.
- `mix_valid`, output, 1: one-cycle pulse when `mix_left`/`mix_right` update.
- `busy`, output, 1: high while a frame is in progress.
- `clip_l`, output, 1: sticky flag, left-side saturation occurred.
- `clip_r`, output, 1: sticky flag, right-side saturation occurred.
- `overrun`, output, 1: sticky flag, a strobe edge arrived while busy.

## Operation
- **Edge detect:** `sample_stb` is registered once; an edge is `stb_q==0 && sample_stb==1`.
- **States:** IDLE, ACC, SAT.
- **IDLE → ACC** on an edge:
  - capture both input buses into snapshot registers;
  - set `idx=0` and `acc_l=acc_r=0`.
- **ACC**, one chip per cycle:
  - `acc_x += snap_x[idx] * gain_x[idx]` (signed × zero-extended unsigned);
  - `idx` increments; after `idx==CHIP_COUNT-1` go to SAT.
- **Accumulator width:** `IN_W+GAIN_W+1+$clog2(CHIP_COUNT)`. It never wraps internally.
- **SAT:**
  - compute `acc_x >>> (7 + master_shift)`, arithmetic, truncating toward −∞;
  - clamp to `[-2^(OUT_W-1), 2^(OUT_W-1)-1]`;
  - register the results into `mix_left`/`mix_right`;
  - pulse `mix_valid`;
  - set `clip_x` if clamping changed the value;
  - return to IDLE.
- **Edge while busy:** ignored and sets `overrun`. There is no queueing.
- **Config writes:**
  - Index < CHIP_COUNT: write `gain_{side}[index]`.
  - Index 31: control register. `cfg_data[2:0]` → `master_shift`. `cfg_data[7]=1` clears all sticky flags (self-clearing; this bit is not stored).
  - Index in CHIP_COUNT..30: ignored.
- **Write timing:** a write takes effect the cycle after `cfg_wr`. An ACC cycle uses the gain value registered at that cycle, so a mid-frame write affects only the chips not yet accumulated.
- **Simultaneous clear and clip:** when a flag clear coincides with a SAT cycle that clips, the clip wins and the flag reads 1.

## Timing
- **Reset values:**
  - `mix_left`, `mix_right` = 0;
  - `mix_valid`, `busy`, `clip_l`, `clip_r`, `overrun` = 0;
  - all gains = 0x80;
  - `master_shift` = 0;
  - state IDLE.
- **Latency:** for an edge first visible at `sample_stb` in cycle T:
  - snapshot at the end of T+1;
  - ACC occupies T+2..T+1+CHIP_COUNT;
  - SAT occurs at T+2+CHIP_COUNT;
  - `mix_valid` is high and outputs are new in cycle T+3+CHIP_COUNT.
- **Busy window:** `busy` is high from T+2 through the SAT cycle inclusive.
- **Minimum strobe spacing:** CHIP_COUNT+3 cycles. The production spacing of 864 cycles leaves ample margin.
- **Reset mid-frame:** all state clears asynchronously, no `mix_valid` is produced, and outputs return to 0.

## Structure
- **Package `spindash_mix_pkg`:**
  - state enum (IDLE/ACC/SAT);
  - `CTRL_INDEX=31`;
  - `UNITY_GAIN=8'h80`;
  - `GAIN_FRAC=7`;
  - side-bit position;
  - function returning the accumulator width.
- **Sub-module `spindash_sat`:** combinational arithmetic shift plus clamp plus clip flag, parametrised by input and output width. It is instantiated twice (left, right).
- **Mixer body:** the FSM, snapshot, gain register files and multiply-accumulate stay in `spindash_mixer`.

## Test plan
1. **Unity sum.** All 9 chips left=1000, right=−1000, default gains; single strobe → `mix_left`=9000, `mix_right`=−9000. `mix_valid` appears exactly 12 cycles after `sample_stb` rises; no flags set.
2. **Saturation.** All chips left=30000, right=−32768 → `mix_left`=32767, `mix_right`=−32768, `clip_l`=`clip_r`=1. Next frame with zero inputs → outputs 0, flags still 1. Write addr 0x1F data 0x80 → flags 0.
3. **Gain and mute.**
   - All gains 0 except left chip 3 = 0x40, chip 3 left=2000 → `mix_left`=1000.
   - Left chip 0 gain 0xFF, input 256, others muted → `mix_left`=510.
   - Input −3 at gain 0x40 → −2 (floor).
4. **Master shift.** Write 0x1F data 0x03, all chips left=8000 → 72000>>3 = `mix_left` 9000, no clip.
5. **Overrun and mid-frame write.**
   - Strobe edges 5 cycles apart → one `mix_valid`, `overrun`=1.
   - Gain write to chip 8 during ACC of chip 2 → new gain is used for chip 8 in the same frame.
   - Write to index 20 → no register change.
6. **Reset mid-frame.** Assert `rst_n`=0 during ACC → `busy`, `mix_*` and flags go to 0 immediately, no `mix_valid`. After release, the next strobe produces a correct frame.

Source files
------------

// File: rtl/spindash_mix_pkg.sv
// Shared types, constants and sizing helpers for the spindash stereo mixer.
package spindash_mix_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAcc  = 2'd1,
        StSat  = 2'd2
    } mix_state_e;

    localparam int unsigned CTRL_INDEX = 31;
    localparam logic [7:0]  UNITY_GAIN = 8'h80;
    localparam int unsigned GAIN_FRAC  = 7;
    localparam int unsigned SIDE_BIT   = 5;
    localparam int unsigned SHIFT_W    = 3;

    // Wide enough that a full frame of worst-case products never wraps.
    function automatic int unsigned acc_width(input int unsigned in_w,
                                              input int unsigned gain_w,
                                              input int unsigned chips);
        return in_w + gain_w + 1 + $clog2(chips);
    endfunction

endpackage

// File: rtl/spindash_sat.sv
// Arithmetic down-shift of a mixer accumulator followed by a signed clamp to the output width.
module spindash_sat
    import spindash_mix_pkg::*;
#(
    parameter int unsigned IN_W  = 29,
    parameter int unsigned OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  acc_i,
    input  logic [SHIFT_W-1:0]      shift_i,
    output logic signed [OUT_W-1:0] sat_o,
    output logic                    clip_o
);

    localparam logic signed [IN_W-1:0] MaxVal = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0] MinVal = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [IN_W-1:0] shifted;

    always_comb begin
        shifted = acc_i >>> (GAIN_FRAC + 32'(shift_i));
        sat_o   = shifted[OUT_W-1:0];
        clip_o  = 1'b0;
        if (shifted > MaxVal) begin
            sat_o  = MaxVal[OUT_W-1:0];
            clip_o = 1'b1;
        end else if (shifted < MinVal) begin
            sat_o  = MinVal[OUT_W-1:0];
            clip_o = 1'b1;
        end
    end

endmodule

// File: rtl/spindash_mixer.sv
// Time-multiplexed stereo mixer: snapshot all chips on a strobe edge, gain-weighted MAC one
// chip per clock, then master shift and saturate to the PDM input width.
module spindash_mixer
    import spindash_mix_pkg::*;
#(
    parameter int unsigned CHIP_COUNT = 9,
    parameter int unsigned IN_W       = 16,
    parameter int unsigned GAIN_W     = 8,
    parameter int unsigned OUT_W      = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sample_stb,
    input  logic [CHIP_COUNT*IN_W-1:0] snd_left_in,
    input  logic [CHIP_COUNT*IN_W-1:0] snd_right_in,
    input  logic                       cfg_wr,
    input  logic [5:0]                 cfg_addr,
    input  logic [7:0]                 cfg_data,
    output logic signed [OUT_W-1:0]    mix_left,
    output logic signed [OUT_W-1:0]    mix_right,
    output logic                       mix_valid,
    output logic                       busy,
    output logic                       clip_l,
    output logic                       clip_r,
    output logic                       overrun
);

    localparam int unsigned AccW  = acc_width(IN_W, GAIN_W, CHIP_COUNT);
    localparam int unsigned ProdW = IN_W + GAIN_W + 1;
    localparam int unsigned IdxW  = (CHIP_COUNT > 1) ? $clog2(CHIP_COUNT) : 1;

    mix_state_e             state_q, state_d;
    logic                   stb_q, edge_q, stb_edge;
    logic [IdxW-1:0]        idx_q, idx_d;
    logic signed [AccW-1:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d;
    logic signed [IN_W-1:0] snap_l_q [CHIP_COUNT];
    logic signed [IN_W-1:0] snap_r_q [CHIP_COUNT];
    logic [GAIN_W-1:0]      gain_l_q [CHIP_COUNT];
    logic [GAIN_W-1:0]      gain_r_q [CHIP_COUNT];
    logic [SHIFT_W-1:0]     shift_q;
    logic signed [ProdW-1:0] prod_l, prod_r;
    logic signed [OUT_W-1:0] sat_l, sat_r, mix_left_q, mix_right_q;
    logic                   sat_clip_l, sat_clip_r;
    logic                   mix_valid_q, clip_l_q, clip_r_q, overrun_q;
    logic [4:0]             cfg_idx;
    logic                   cfg_ctrl, flag_clr;

    assign stb_edge = sample_stb & ~stb_q;
    assign cfg_idx  = cfg_addr[4:0];
    assign cfg_ctrl = cfg_wr && (cfg_idx == 5'(CTRL_INDEX));
    assign flag_clr = cfg_ctrl && cfg_data[7];

    // Gains are zero-extended so 0xFF reads as +255/128 rather than a negative weight.
    assign prod_l = ProdW'(snap_l_q[idx_q]) * ProdW'($signed({1'b0, gain_l_q[idx_q]}));
    assign prod_r = ProdW'(snap_r_q[idx_q]) * ProdW'($signed({1'b0, gain_r_q[idx_q]}));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_l_d = acc_l_q;
        acc_r_d = acc_r_q;
        unique case (state_q)
            StIdle: begin
                if (edge_q) begin
                    state_d = StAcc;
                    idx_d   = '0;
                    acc_l_d = '0;
                    acc_r_d = '0;
                end
            end
            StAcc: begin
                acc_l_d = acc_l_q + AccW'(prod_l);
                acc_r_d = acc_r_q + AccW'(prod_r);
                idx_d   = idx_q + 1'b1;
                if (idx_q == IdxW'(CHIP_COUNT - 1)) state_d = StSat;
            end
            StSat:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            stb_q   <= 1'b0;
            edge_q  <= 1'b0;
            idx_q   <= '0;
            acc_l_q <= '0;
            acc_r_q <= '0;
            for (int unsigned i = 0; i < CHIP_COUNT; i++) begin
                snap_l_q[i] <= '0;
                snap_r_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            stb_q   <= sample_stb;
            edge_q  <= stb_edge;
            idx_q   <= idx_d;
            acc_l_q <= acc_l_d;
            acc_r_q <= acc_r_d;
            if (state_q == StIdle && edge_q) begin
                for (int unsigned i = 0; i < CHIP_COUNT; i++) begin
                    snap_l_q[i] <= snd_left_in[i*IN_W +: IN_W];
                    snap_r_q[i] <= snd_right_in[i*IN_W +: IN_W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < CHIP_COUNT; i++) begin
                gain_l_q[i] <= GAIN_W'(UNITY_GAIN);
                gain_r_q[i] <= GAIN_W'(UNITY_GAIN);
            end
            shift_q <= '0;
        end else begin
            for (int unsigned i = 0; i < CHIP_COUNT; i++) begin
                if (cfg_wr && cfg_idx == 5'(i)) begin
                    if (cfg_addr[SIDE_BIT]) gain_r_q[i] <= GAIN_W'(cfg_data);
                    else                    gain_l_q[i] <= GAIN_W'(cfg_data);
                end
            end
            if (cfg_ctrl) shift_q <= cfg_data[SHIFT_W-1:0];
        end
    end

    spindash_sat #(
        .IN_W  (AccW),
        .OUT_W (OUT_W)
    ) u_sat_l (
        .acc_i   (acc_l_q),
        .shift_i (shift_q),
        .sat_o   (sat_l),
        .clip_o  (sat_clip_l)
    );

    spindash_sat #(
        .IN_W  (AccW),
        .OUT_W (OUT_W)
    ) u_sat_r (
        .acc_i   (acc_r_q),
        .shift_i (shift_q),
        .sat_o   (sat_r),
        .clip_o  (sat_clip_r)
    );

    // A set in the same cycle as a clear wins so no clip event is ever lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mix_left_q  <= '0;
            mix_right_q <= '0;
            mix_valid_q <= 1'b0;
            clip_l_q    <= 1'b0;
            clip_r_q    <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            mix_valid_q <= (state_q == StSat);
            if (state_q == StSat) begin
                mix_left_q  <= sat_l;
                mix_right_q <= sat_r;
            end
            if (state_q == StSat && sat_clip_l) clip_l_q <= 1'b1;
            else if (flag_clr)                  clip_l_q <= 1'b0;
            if (state_q == StSat && sat_clip_r) clip_r_q <= 1'b1;
            else if (flag_clr)                  clip_r_q <= 1'b0;
            if (edge_q && state_q != StIdle)    overrun_q <= 1'b1;
            else if (flag_clr)                  overrun_q <= 1'b0;
        end
    end

    assign mix_left  = mix_left_q;
    assign mix_right = mix_right_q;
    assign mix_valid = mix_valid_q;
    assign busy      = (state_q != StIdle);
    assign clip_l    = clip_l_q;
    assign clip_r    = clip_r_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_spindash_mixer.sv
// Self-checking bench for spindash_mixer: vector table plus hand-built multi-cycle sequences.
module tb_spindash_mixer;

    localparam int N = 9;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               sample_stb = 1'b0;
    logic               cfg_wr = 1'b0;
    logic [5:0]         cfg_addr = '0;
    logic [7:0]         cfg_data = '0;
    logic [N*16-1:0]    snd_l, snd_r;
    logic signed [15:0] mix_left, mix_right;
    logic               mix_valid, busy, clip_l, clip_r, overrun;

    int lv[N], rv[N], gl[N], gr[N];
    int shift;

    typedef struct { longint l; longint r; } exp_t;
    exp_t sb[$];

    typedef struct { int lin; int rin; longint el; longint er; bit cl; bit cr; } vec_t;
    vec_t tbl[6];

    int n_pass = 0;
    int n_checks = 0;
    int valid_seen = 0;

    always #5 clk = ~clk;

    always_comb begin
        snd_l = '0;
        snd_r = '0;
        for (int i = 0; i < N; i++) begin
            snd_l[i*16 +: 16] = 16'(lv[i]);
            snd_r[i*16 +: 16] = 16'(rv[i]);
        end
    end

    spindash_mixer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_stb   (sample_stb),
        .snd_left_in  (snd_l),
        .snd_right_in (snd_r),
        .cfg_wr       (cfg_wr),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .mix_left     (mix_left),
        .mix_right    (mix_right),
        .mix_valid    (mix_valid),
        .busy         (busy),
        .clip_l       (clip_l),
        .clip_r       (clip_r),
        .overrun      (overrun)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Scoreboard: every mix_valid pops one expected frame.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && mix_valid) begin
            valid_seen++;
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_valid: got frame %0d/%0d, expected none", mix_left,
                         mix_right);
            end else begin
                e = sb.pop_front();
                chk("mix_left", mix_left, e.l);
                chk("mix_right", mix_right, e.r);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            gl[i] = 128;
            gr[i] = 128;
        end
        shift = 0;
    endtask

    function automatic longint model_side(input bit right);
        longint acc = 0;
        for (int i = 0; i < N; i++)
            acc += right ? longint'(rv[i]) * gr[i] : longint'(lv[i]) * gl[i];
        acc = acc >>> (7 + shift);
        if (acc > 32767) acc = 32767;
        else if (acc < -32768) acc = -32768;
        return acc;
    endfunction

    task automatic write_cfg(input logic [5:0] addr, input logic [7:0] data);
        int idx;
        idx = int'(addr[4:0]);
        cfg_wr = 1'b1;
        cfg_addr = addr;
        cfg_data = data;
        tick();
        cfg_wr = 1'b0;
        if (idx < N) begin
            if (addr[5]) gr[idx] = int'(data);
            else gl[idx] = int'(data);
        end else if (idx == 31) begin
            shift = int'(data[2:0]);
        end
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        forever begin
            @(negedge clk);
            if (mix_valid || lat >= 40) break;
            tick();
            lat++;
        end
        if (!mix_valid) begin
            n_checks++;
            $display("FAIL frame_timeout: got no mix_valid after %0d cycles, expected 12", lat);
        end
        tick();
        sample_stb = 1'b0;
        tick();
    endtask

    task automatic run_frame(input longint el, input longint er);
        int lat;
        sb.push_back('{l: el, r: er});
        sample_stb = 1'b1;
        wait_valid(lat);
        chk("latency", lat, 12);
    endtask

    task automatic run_model_frame();
        run_frame(model_side(1'b0), model_side(1'b1));
    endtask

    task automatic fill(input int l, input int r);
        for (int i = 0; i < N; i++) begin
            lv[i] = l;
            rv[i] = r;
        end
    endtask

    initial begin
        int lat;
        int vs;
        model_reset();
        fill(0, 0);
        tbl[0] = '{1000, -1000, 9000, -9000, 1'b0, 1'b0};
        tbl[1] = '{0, 0, 0, 0, 1'b0, 1'b0};
        tbl[2] = '{-1, 1, -9, 9, 1'b0, 1'b0};
        tbl[3] = '{3641, -3640, 32767, -32760, 1'b1, 1'b0};
        tbl[4] = '{30000, -32768, 32767, -32768, 1'b1, 1'b1};
        tbl[5] = '{0, 0, 0, 0, 1'b1, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_mix_left", mix_left, 0);
        chk("rst_mix_right", mix_right, 0);
        chk("rst_mix_valid", mix_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_clip_l", clip_l, 0);
        chk("rst_clip_r", clip_r, 0);
        chk("rst_overrun", overrun, 0);
        rst_n = 1'b1;
        tick();

        // Default unity gains, sticky clip flags tracked per entry.
        for (int k = 0; k < 6; k++) begin
            fill(tbl[k].lin, tbl[k].rin);
            run_frame(tbl[k].el, tbl[k].er);
            chk("tbl_clip_l", clip_l, tbl[k].cl);
            chk("tbl_clip_r", clip_r, tbl[k].cr);
            chk("tbl_overrun", overrun, 0);
        end
        write_cfg(6'h1F, 8'h80);
        chk("clr_clip_l", clip_l, 0);
        chk("clr_clip_r", clip_r, 0);

        // Gain and mute.
        for (int i = 0; i < N; i++) begin
            write_cfg({1'b0, 5'(i)}, 8'h00);
            write_cfg({1'b1, 5'(i)}, 8'h00);
        end
        write_cfg(6'd3, 8'h40);
        fill(0, 500);
        lv[3] = 2000;
        run_frame(1000, 0);
        write_cfg(6'd3, 8'h00);
        write_cfg(6'd0, 8'hFF);
        lv[3] = 0;
        lv[0] = 256;
        run_frame(510, 0);
        write_cfg(6'd0, 8'h40);
        lv[0] = -3;
        run_frame(-2, 0);

        // Master shift with unity gains restored.
        for (int i = 0; i < N; i++) begin
            write_cfg({1'b0, 5'(i)}, 8'h80);
            write_cfg({1'b1, 5'(i)}, 8'h80);
        end
        write_cfg(6'h1F, 8'h03);
        fill(8000, -8000);
        run_frame(9000, -9000);
        chk("shift_clip_l", clip_l, 0);
        chk("shift_clip_r", clip_r, 0);
        write_cfg(6'h1F, 8'h00);

        // Second edge 5 cycles after the first lands mid-frame.
        fill(100, -200);
        vs = valid_seen;
        sb.push_back('{l: 900, r: -1800});
        sample_stb = 1'b1;
        tick();
        tick();
        sample_stb = 1'b0;
        repeat (3) tick();
        sample_stb = 1'b1;
        wait_valid(lat);
        repeat (15) tick();
        chk("overrun_valids", valid_seen - vs, 1);
        chk("overrun_flag", overrun, 1);
        write_cfg(6'h1F, 8'h80);
        chk("overrun_clr", overrun, 0);

        // Mid-frame writes: chip 8 left not yet summed, chip 0 right already summed.
        fill(1000, 1000);
        sb.push_back('{l: 8000, r: 9000});
        sample_stb = 1'b1;
        repeat (4) tick();
        write_cfg(6'd8, 8'h00);
        write_cfg(6'h20, 8'h00);
        wait_valid(lat);
        run_model_frame();
        write_cfg(6'd20, 8'h00);
        write_cfg(6'h34, 8'h00);
        run_model_frame();

        // Reset during ACC with overrun pending.
        sample_stb = 1'b1;
        repeat (3) tick();
        sample_stb = 1'b0;
        tick();
        sample_stb = 1'b1;
        repeat (2) tick();
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_overrun", overrun, 1);
        vs = valid_seen;
        rst_n = 1'b0;
        sample_stb = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_mix_left", mix_left, 0);
        chk("mid_rst_mix_right", mix_right, 0);
        chk("mid_rst_overrun", overrun, 0);
        chk("mid_rst_valid", mix_valid, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        model_reset();
        repeat (15) tick();
        chk("mid_rst_no_valid", valid_seen - vs, 0);
        for (int i = 0; i < N; i++) begin
            lv[i] = 1000 * i - 3000;
            rv[i] = 50 - 777 * i;
        end
        run_model_frame();

        repeat (5) tick();
        chk("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
